// File: rtl/subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor.
//   state_e       : controller state encoding (IDLE / RUN / DONE)
//   DEFAULT_WIDTH : default operand width in bits
package subtractor_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage : subtractor_pkg

// File: rtl/fs_cell.sv
// 1-bit full subtractor, purely combinational.
//   x   : minuend bit
//   y   : subtrahend bit
//   bin : borrow in
//   d   : difference bit  x - y - bin
//   bo  : borrow out
module fs_cell (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bo
);

  assign d  = x ^ y ^ bin;
  assign bo = (~x & y) | (~(x ^ y) & bin);

endmodule : fs_cell

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial subtractor controller: computes a - b mod 2^WIDTH one bit per
// cycle, LSB first, through a single full-subtractor cell.
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset
//   start      : begin a subtraction (accepted only in IDLE)
//   a, b       : minuend / subtrahend, captured on an accepted start
//   busy       : high during the WIDTH processing cycles
//   done       : one-cycle pulse when a result is registered
//   diff       : last completed result, held until the next completion
//   borrow_out : final borrow of the last result (a < b unsigned)
module serial_subtractor_ctrl
  import subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  state_e             state_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   res_q;
  logic               borrow_q;
  logic [CNT_W-1:0]   cnt_q;

  logic               cell_d;
  logic               cell_bo;
  logic               last_bit_c;
  logic [WIDTH-1:0]   res_next_c;

  // Single subtractor cell fed by the operand LSBs and the running borrow.
  fs_cell u_fs_cell (
    .x   (a_q[0]),
    .y   (b_q[0]),
    .bin (borrow_q),
    .d   (cell_d),
    .bo  (cell_bo)
  );

  // Counter still holds WIDTH-1 during the final RUN cycle, so it never wraps.
  assign last_bit_c = (cnt_q == CNT_W'(WIDTH - 1));
  // Difference bits enter at the MSB so the LSB ends up at bit 0.
  assign res_next_c = {cell_d, res_q[WIDTH-1:1]};

  // Controller state, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      res_q      <= '0;
      borrow_q   <= 1'b0;
      cnt_q      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_q      <= a;
            b_q      <= b;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            busy     <= 1'b1;
            state_q  <= RUN;
          end
        end
        RUN: begin
          res_q    <= res_next_c;
          borrow_q <= cell_bo;
          a_q      <= a_q >> 1;
          b_q      <= b_q >> 1;
          cnt_q    <= cnt_q + CNT_W'(1);
          if (last_bit_c) begin
            busy       <= 1'b0;
            done       <= 1'b1;
            diff       <= res_next_c;
            borrow_out <= cell_bo;
            state_q    <= DONE;
          end
        end
        DONE: begin
          // start is deliberately ignored here; IDLE is always visited first.
          done    <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule : serial_subtractor_ctrl

// File: tb/tb_serial_subtractor_ctrl.sv
// Scoreboard bench for serial_subtractor_ctrl (WIDTH=8): a cycle-level
// reference model predicts busy/done timing and pushes expected results;
// a negedge monitor pops and compares.
module tb_serial_subtractor_ctrl;

  localparam int unsigned W = 8;

  typedef struct packed {
    logic [W-1:0] d;
    logic         bo;
  } res_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow_out;

  res_t        exp_q[$];
  res_t        last_exp = '0;
  res_t        popped;
  int unsigned ph = 0;        // 0 idle, 1..W busy, W+1 done
  int unsigned done_cnt = 0;
  int          checks = 0;
  int          errors = 0;
  logic        exp_busy;
  logic        exp_done;

  serial_subtractor_ctrl #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out)
  );

  always #5 clk = ~clk;

  function automatic res_t ref_sub(logic [W-1:0] x, logic [W-1:0] y);
    res_t r;
    int   dv;
    dv   = int'(x) - int'(y);
    r.d  = W'(dv);
    r.bo = (dv < 0);
    return r;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, expv, $time);
    end
  endtask

  // Reference model: operation phase advanced on each clock edge.
  always @(posedge clk) begin
    if (rst) begin
      ph = 0;
      exp_q.delete();
      last_exp = '0;
    end else if (ph == 0) begin
      if (start) begin
        ph = 1;
        exp_q.push_back(ref_sub(a, b));
      end
    end else if (ph == W) begin
      ph = W + 1;
      if (exp_q.size() > 0) last_exp = exp_q[0];
    end else if (ph == W + 1) begin
      ph = 0;
    end else begin
      ph = ph + 1;
    end
  end

  // Monitor: compare outputs against the model away from the active edge.
  always @(negedge clk) begin
    exp_busy = (ph >= 1) && (ph <= W);
    exp_done = (ph == W + 1);
    chk("busy", 32'(busy), 32'(exp_busy));
    chk("done", 32'(done), 32'(exp_done));
    if (done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        chk("done_without_op", 32'd1, 32'd0);
      end else begin
        popped = exp_q.pop_front();
        chk("result_diff", 32'(diff), 32'(popped.d));
        chk("result_borrow", 32'(borrow_out), 32'(popped.bo));
      end
    end else begin
      chk("held_diff", 32'(diff), 32'(last_exp.d));
      chk("held_borrow", 32'(borrow_out), 32'(last_exp.bo));
    end
  end

  // One clock of stimulus; inputs change just after the active edge.
  task automatic cyc(logic s, logic [W-1:0] av, logic [W-1:0] bv, logic r);
    start = s;
    a     = av;
    b     = bv;
    rst   = r;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_rand();
    cyc(1'b0, W'($urandom), W'($urandom), 1'b0);
  endtask

  // Full operation: operands scrambled after acceptance.
  task automatic op(logic [W-1:0] av, logic [W-1:0] bv);
    cyc(1'b1, av, bv, 1'b0);
    repeat (W + 1) idle_rand();
  endtask

  int unsigned d0;

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    @(posedge clk); #1;
    cyc(1'b1, 8'h12, 8'h34, 1'b1);   // reset wins over start
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_diff", 32'(diff), 32'd0);
    cyc(1'b0, '0, '0, 1'b0);

    op(8'h05, 8'h03);
    chk("r032_diff", 32'(diff), 32'h02);
    chk("r032_borrow", 32'(borrow_out), 32'd0);
    op(8'h03, 8'h05);
    chk("r033_diff", 32'(diff), 32'hFE);
    chk("r033_borrow", 32'(borrow_out), 32'd1);
    op(8'h00, 8'hFF);
    chk("r034a_diff", 32'(diff), 32'h01);
    chk("r034a_borrow", 32'(borrow_out), 32'd1);
    op(8'hAA, 8'hAA);
    chk("r034b_diff", 32'(diff), 32'h00);
    chk("r034b_borrow", 32'(borrow_out), 32'd0);

    // Second start pulse with new operands mid-operation is ignored.
    d0 = done_cnt;
    cyc(1'b1, 8'h10, 8'h01, 1'b0);
    cyc(1'b0, 8'h10, 8'h01, 1'b0);
    cyc(1'b0, 8'h10, 8'h01, 1'b0);
    cyc(1'b1, 8'hFF, 8'hFF, 1'b0);
    repeat (W - 2) cyc(1'b0, 8'hFF, 8'hFF, 1'b0);
    chk("r035_diff", 32'(diff), 32'h0F);
    chk("r035_borrow", 32'(borrow_out), 32'd0);
    chk("r035_pulses", done_cnt - d0, 32'd1);

    // Reset mid-RUN abandons the operation.
    d0 = done_cnt;
    cyc(1'b1, 8'h55, 8'h11, 1'b0);
    cyc(1'b0, 8'h55, 8'h11, 1'b0);
    cyc(1'b0, 8'h55, 8'h11, 1'b0);
    cyc(1'b0, 8'h55, 8'h11, 1'b1);
    chk("r036_busy", 32'(busy), 32'd0);
    chk("r036_diff", 32'(diff), 32'h00);
    repeat (W + 2) cyc(1'b0, '0, '0, 1'b0);
    chk("r036_no_done", done_cnt - d0, 32'd0);
    op(8'h07, 8'h02);
    chk("r036_diff2", 32'(diff), 32'h05);

    // Continuous start: one result every W+2 cycles.
    d0 = done_cnt;
    repeat (30) cyc(1'b1, 8'h80, 8'h01, 1'b0);
    chk("r037_pulses", done_cnt - d0, 32'd3);
    chk("r037_diff", 32'(diff), 32'h7F);
    repeat (W + 2) cyc(1'b0, '0, '0, 1'b0);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom % 3) != 0, W'($urandom), W'($urandom), ($urandom % 60) == 0);
    end
    repeat (W + 3) cyc(1'b0, '0, '0, 1'b0);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule : tb_serial_subtractor_ctrl
